// File: rtl/pulpemu_rst_pkg.sv
// Shared types and widths for the emulation reset conditioner.
package pulpemu_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        JTAG   = 2'd2,
        RUN    = 2'd3
    } rst_state_e;

    localparam int RST_CNT_W = 8;

endpackage

// File: rtl/pulpemu_debounce.sv
// Two-or-more flop synchroniser followed by an optional stable-level debounce counter.
module pulpemu_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= {SYNC_STAGES{RESET_VAL}};
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 1) begin : g_bypass
            // Synchroniser only: no extra flop, so the lock-loss path stays at SYNC_STAGES edges.
            assign dout = sync_s;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          db_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt  <= '0;
                    db_q <= RESET_VAL;
                end else if (sync_s == db_q) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt  <= '0;
                    db_q <= sync_s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign dout = db_q;
        end
    endgenerate

endmodule

// File: rtl/pulpemu_rst_gen.sv
// Reset conditioner: debounced button + lock flag drive an ordered release, TAP reset first, SoC last.
module pulpemu_rst_gen
    import pulpemu_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int HOLD_CYCLES        = 1024,
    parameter int JTAG_RELEASE_DELAY = 16
) (
    input  logic                 ref_clk,
    input  logic                 rst_i,
    input  logic                 btn_reset_i,
    input  logic                 clk_locked_i,
    output logic                 soc_rst_no,
    output logic                 jtag_trst_no,
    output logic                 rst_active_o,
    output logic [RST_CNT_W-1:0] rst_count_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > JTAG_RELEASE_DELAY) ? HOLD_CYCLES : JTAG_RELEASE_DELAY;
    localparam int CW      = $clog2((CNT_MAX < 2) ? 2 : CNT_MAX);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] JTAG_LD = CW'(JTAG_RELEASE_DELAY - 1);

    generate
        if (SYNC_STAGES < 2)        begin : g_err_sync  $error("SYNC_STAGES must be >= 2");        end
        if (DEBOUNCE_CYCLES < 1)    begin : g_err_db    $error("DEBOUNCE_CYCLES must be >= 1");    end
        if (HOLD_CYCLES < 1)        begin : g_err_hold  $error("HOLD_CYCLES must be >= 1");        end
        if (JTAG_RELEASE_DELAY < 1) begin : g_err_jtag  $error("JTAG_RELEASE_DELAY must be >= 1"); end
    endgenerate

    logic       btn_db;
    logic       locked_s;
    logic       cause;
    rst_state_e state;
    logic [CW-1:0] cnt;

    pulpemu_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b1)
    ) u_btn (
        .clk (ref_clk),
        .rst (rst_i),
        .din (btn_reset_i),
        .dout(btn_db)
    );

    pulpemu_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(1),
        .RESET_VAL      (1'b0)
    ) u_lock (
        .clk (ref_clk),
        .rst (rst_i),
        .din (clk_locked_i),
        .dout(locked_s)
    );

    assign cause = btn_db | ~locked_s;

    // Outputs are loaded alongside the state transition so they always match the state register.
    always_ff @(posedge ref_clk) begin
        if (rst_i) begin
            state        <= ASSERT;
            cnt          <= '0;
            soc_rst_no   <= 1'b0;
            jtag_trst_no <= 1'b0;
            rst_active_o <= 1'b1;
            rst_count_o  <= '0;
        end else begin
            case (state)
                ASSERT: begin
                    if (!cause) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                    end
                end
                HOLD: begin
                    if (cause) begin
                        state <= ASSERT;
                    end else if (cnt == '0) begin
                        state        <= JTAG;
                        cnt          <= JTAG_LD;
                        jtag_trst_no <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                JTAG: begin
                    if (cause) begin
                        state        <= ASSERT;
                        jtag_trst_no <= 1'b0;
                    end else if (cnt == '0) begin
                        state        <= RUN;
                        soc_rst_no   <= 1'b1;
                        rst_active_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (cause) begin
                        state        <= ASSERT;
                        soc_rst_no   <= 1'b0;
                        jtag_trst_no <= 1'b0;
                        rst_active_o <= 1'b1;
                        if (rst_count_o != {RST_CNT_W{1'b1}})
                            rst_count_o <= rst_count_o + 1'b1;
                    end
                end
                default: begin
                    state        <= ASSERT;
                    soc_rst_no   <= 1'b0;
                    jtag_trst_no <= 1'b0;
                    rst_active_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
